// File: rtl/vlsu_pkg.sv
// Shared types and constants for the vector load/store address generator.
// State encoding, mode constants and element-width helpers.
package vlsu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic MODE_UNIT    = 1'b0;
  localparam logic MODE_STRIDED = 1'b1;

  typedef enum logic [1:0] {
    EW_1B = 2'd0,
    EW_2B = 2'd1,
    EW_4B = 2'd2,
    EW_8B = 2'd3
  } ew_e;

  // Element width code -> log2(bytes per element).
  function automatic logic [1:0] ew_shift(input logic [1:0] ew);
    logic [1:0] sh;
    unique case (ew)
      EW_1B:   sh = 2'd0;
      EW_2B:   sh = 2'd1;
      EW_4B:   sh = 2'd2;
      default: sh = 2'd3;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/vlsu_addr_step.sv
// Next element address: unit-stride shift from base, or
// running accumulate of a signed stride. Wraps modulo 2**ADDR_W.
module vlsu_addr_step
  import vlsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic              mode,
  input  logic [1:0]        ew,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  input  logic [ADDR_W-1:0] cur_addr,
  input  logic [IDX_W-1:0]  nxt_idx,
  output logic [ADDR_W-1:0] nxt_addr
);

  logic [ADDR_W-1:0] ofs;

  always_comb begin
    ofs = ADDR_W'(nxt_idx) << ew_shift(ew);
    if (mode == MODE_STRIDED)
      nxt_addr = cur_addr + stride;
    else
      nxt_addr = base + ofs;
  end

endmodule

// File: rtl/vlsu_agen.sv
// Vector load/store element sequencer: one address request per
// element over valid/ready, with index, last flag and done pulse.
module vlsu_agen
  import vlsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vl_we,
  input  logic [IDX_W:0]    vl_in,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  input  logic              mode,
  input  logic [1:0]        ew,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic [IDX_W-1:0]  req_idx,
  output logic              req_last
);

  localparam logic [IDX_W:0] VL_MAX = {1'b1, {IDX_W{1'b0}}};

  state_e            state_q;
  logic [IDX_W:0]    vl_q;
  logic [IDX_W:0]    snap_vl_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] stride_q;
  logic              mode_q;
  logic [1:0]        ew_q;
  logic [IDX_W-1:0]  idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic              last_q;
  logic              valid_q;
  logic              done_q;

  logic [IDX_W:0]    vl_d;
  logic [IDX_W:0]    idx_nx;
  logic              last_d;
  logic [ADDR_W-1:0] addr_d;

  assign vl_d   = (vl_in > VL_MAX) ? VL_MAX : vl_in;
  assign idx_nx = {1'b0, idx_q} + (IDX_W+1)'(1);
  assign last_d = (idx_nx == snap_vl_q - (IDX_W+1)'(1));

  vlsu_addr_step #(
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_step (
    .mode     (mode_q),
    .ew       (ew_q),
    .base     (base_q),
    .stride   (stride_q),
    .cur_addr (addr_q),
    .nxt_idx  (idx_nx[IDX_W-1:0]),
    .nxt_addr (addr_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vl_q      <= '0;
      snap_vl_q <= '0;
      base_q    <= '0;
      stride_q  <= '0;
      mode_q    <= MODE_UNIT;
      ew_q      <= '0;
      idx_q     <= '0;
      addr_q    <= '0;
      last_q    <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (vl_we)
        vl_q <= vl_d;
      unique case (state_q)
        IDLE: begin
          // abort outranks start even while idle
          if (start && !abort) begin
            snap_vl_q <= vl_q;
            base_q    <= base;
            stride_q  <= stride;
            mode_q    <= mode;
            ew_q      <= ew;
            if (vl_q == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= RUN;
              valid_q <= 1'b1;
              idx_q   <= '0;
              addr_q  <= base;
              last_q  <= (vl_q == (IDX_W+1)'(1));
            end
          end
        end
        RUN: begin
          if (abort || (req_ready && last_q)) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            idx_q   <= '0;
            addr_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= !abort;
          end else if (req_ready) begin
            idx_q  <= idx_nx[IDX_W-1:0];
            addr_q <= addr_d;
            last_q <= last_d;
          end
        end
      endcase
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign req_valid = valid_q;
  assign req_addr  = addr_q;
  assign req_idx   = idx_q;
  assign req_last  = last_q;

endmodule

// File: tb/tb_vlsu_agen.sv
// Scoreboard bench for vlsu_agen: stimulus pushes expected requests,
// a negedge monitor pops and compares on every handshake and done.
module tb_vlsu_agen;

  localparam int AW = 32;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vl_we = 1'b0;
  logic [IW:0]   vl_in = '0;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW-1:0] stride = '0;
  logic          mode = 1'b0;
  logic [1:0]    ew = '0;
  logic          abort = 1'b0;
  logic          busy;
  logic          done;
  logic          req_valid;
  logic          req_ready = 1'b0;
  logic [AW-1:0] req_addr;
  logic [IW-1:0] req_idx;
  logic          req_last;

  vlsu_agen #(.ADDR_W(AW), .IDX_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vl_we     (vl_we),
    .vl_in     (vl_in),
    .start     (start),
    .base      (base),
    .stride    (stride),
    .mode      (mode),
    .ew        (ew),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_idx   (req_idx),
    .req_last  (req_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_done;
    logic [AW-1:0] addr;
    int            idx;
    bit            last;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   vl_model = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > (1 << IW)) ? (1 << IW) : v;
  endfunction

  // Reference address: element i of a unit or strided sweep.
  function automatic logic [AW-1:0] ref_addr(input logic [AW-1:0] b,
      input logic [AW-1:0] s, input logic m, input logic [1:0] w,
      input int i);
    logic [AW-1:0] ii;
    ii = AW'(i);
    return m ? b + ii * s : b + ii * (AW'(1) << w);
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (done) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL done_unexpected actual=1 required=0");
        end else begin
          e = sbq.pop_front();
          chk("done_kind", 64'(e.is_done), 64'd1);
        end
      end
      if (req_valid && req_ready) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL req_unexpected addr=%0h idx=%0d", req_addr, req_idx);
        end else begin
          e = sbq.pop_front();
          chk("req_kind", 64'(e.is_done), 64'd0);
          chk("req_addr", 64'(req_addr), 64'(e.addr));
          chk("req_idx", 64'(req_idx), 64'(e.idx));
          chk("req_last", 64'(req_last), 64'(e.last));
        end
      end
    end
  end

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1; e.addr = '0; e.idx = 0; e.last = 1'b0;
    sbq.push_back(e);
  endtask

  task automatic set_vl(input int v);
    vl_we = 1'b1;
    vl_in = (IW+1)'(v);
    @(posedge clk); #1;
    vl_we = 1'b0;
    vl_model = sat(v);
  endtask

  // Entered and left at posedge+1.
  task automatic run_op(input logic [AW-1:0] b, input logic [AW-1:0] s,
      input logic m, input logic [1:0] w, input int abort_at,
      input int rdy_pct, input int hold_idx, input bit we_mid,
      input bit we_start);
    int   n;
    int   k;
    int   cyc;
    int   holds;
    bit   rdy;
    bit   ab;
    exp_t e;
    n = vl_model; k = 0; cyc = 0; holds = 0;
    base = b; stride = s; mode = m; ew = w; start = 1'b1;
    if (we_start) begin
      vl_we = 1'b1;
      vl_in = (IW+1)'($urandom_range(31));
    end
    if (n == 0) push_done();
    @(posedge clk); #1;
    start = 1'b0;
    if (vl_we) begin
      vl_model = sat(int'(vl_in));
      vl_we = 1'b0;
    end
    if (n == 0) begin
      chk("zero_done", 64'(done), 64'd1);
      chk("zero_valid", 64'(req_valid), 64'd0);
      chk("zero_busy", 64'(busy), 64'd0);
      return;
    end
    chk("start_busy", 64'(busy), 64'd1);
    while (k < n) begin
      chk("run_valid", 64'(req_valid), 64'd1);
      chk("run_idx", 64'(req_idx), 64'(k));
      chk("run_addr", 64'(req_addr), 64'(ref_addr(b, s, m, w, k)));
      chk("run_last", 64'(req_last), 64'(k == n - 1));
      rdy = ($urandom_range(99) < rdy_pct);
      if (k == hold_idx && holds < 2) begin
        rdy = 1'b0;
        holds++;
      end
      ab = (k == abort_at);
      req_ready = rdy;
      abort = ab;
      if (ab) start = 1'b1;
      if (we_mid && cyc == 1) begin
        vl_we = 1'b1;
        vl_in = (IW+1)'($urandom_range(31));
      end
      if (rdy) begin
        e.is_done = 1'b0;
        e.addr = ref_addr(b, s, m, w, k);
        e.idx = k;
        e.last = (k == n - 1);
        sbq.push_back(e);
      end
      @(posedge clk); #1;
      if (vl_we) begin
        vl_model = sat(int'(vl_in));
        vl_we = 1'b0;
      end
      abort = 1'b0; start = 1'b0; req_ready = 1'b0;
      if (rdy) k++;
      cyc++;
      if (ab) begin
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_valid", 64'(req_valid), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        return;
      end
      if (cyc > 400) begin
        total++; bad++;
        $display("FAIL run_timeout actual=%0d required=%0d", k, n);
        return;
      end
    end
    push_done();
    chk("end_done", 64'(done), 64'd1);
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_valid", 64'(req_valid), 64'd0);
  endtask

  task automatic reset_mid_op();
    exp_t e;
    int   k;
    set_vl(8);
    base = 32'h2000; stride = '0; mode = 1'b0; ew = 2'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (k < 5) begin
      req_ready = 1'b1;
      e.is_done = 1'b0;
      e.addr = 32'h2000 + AW'(k * 2);
      e.idx = k;
      e.last = 1'b0;
      sbq.push_back(e);
      @(posedge clk); #1;
      k++;
    end
    req_ready = 1'b0;
    chk("rst_pre_idx", 64'(req_idx), 64'd5);
    rst_n = 1'b0;
    vl_model = 0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(req_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_addr", 64'(req_addr), 64'd0);
    chk("rst_idx", 64'(req_idx), 64'd0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'h3000, '0, 1'b0, 2'd0, -1, 100, -1, 1'b0, 1'b0);
  endtask

  initial begin
    int  v;
    int  ab;
    logic m;
    #2;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_valid", 64'(req_valid), 64'd0);
    chk("reset_addr", 64'(req_addr), 64'd0);
    chk("reset_last", 64'(req_last), 64'd0);
    #20;
    rst_n = 1'b1;
    @(posedge clk); #1;

    set_vl(4);
    run_op(32'h1000, '0, 1'b0, 2'd2, -1, 100, -1, 1'b0, 1'b0);
    set_vl(3);
    run_op(32'h10, 32'hFFFF_FFF8, 1'b1, 2'd0, -1, 100, 1, 1'b0, 1'b0);
    set_vl(2);
    run_op(32'hFFFF_FFFC, 32'd8, 1'b1, 2'd2, -1, 100, -1, 1'b0, 1'b0);
    set_vl(0);
    run_op(32'h40, '0, 1'b0, 2'd0, -1, 100, -1, 1'b0, 1'b0);
    set_vl(31);
    chk("vl_saturate", 64'(vl_model), 64'd16);
    run_op(32'h8000, '0, 1'b0, 2'd3, -1, 100, -1, 1'b0, 1'b0);
    set_vl(8);
    run_op(32'h500, '0, 1'b0, 2'd1, 2, 100, -1, 1'b1, 1'b0);
    set_vl(5);
    run_op(32'h600, 32'd12, 1'b1, 2'd0, -1, 100, -1, 1'b0, 1'b1);
    reset_mid_op();

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(2) == 0) set_vl($urandom_range(31));
      v = vl_model;
      ab = (v > 1 && $urandom_range(3) == 0) ? $urandom_range(v - 2) : -1;
      m = 1'($urandom_range(1));
      run_op($urandom, $urandom, m, 2'($urandom_range(3)), ab,
             $urandom_range(40, 100), -1, 1'($urandom_range(1)),
             ($urandom_range(4) == 0));
      if ($urandom_range(1) == 1) begin
        @(posedge clk); #1;
      end
    end

    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vlsu_agen.md
# vlsu_agen

Parametrised vector load/store address generator, the next-generation element sequencer of the vector load/store unit. It holds a programmable vector length, accepts a start command carrying base, stride, mode and element width, and issues one address request per element to the memory port over a valid/ready handshake, with element index and last-element flag. It sits between vector decode (vl writes, start) and the data-memory request arbiter.

## Interface
Parameters:
- ADDR_W, 32, address and stride width
- IDX_W, 4, element-index width; maximum vl = 2**IDX_W

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- vl_we  in  1  write vl register
- vl_in  in  IDX_W+1  new vector length, 0..2**IDX_W; larger values saturate to 2**IDX_W
- start  in  1  start command; sampled in IDLE only
- base  in  ADDR_W  element-0 address
- stride  in  ADDR_W  byte stride, two's complement (STRIDED mode only)
- mode  in  1  0 = UNIT, 1 = STRIDED
- ew  in  2  element width: 0=1B, 1=2B, 2=4B, 3=8B
- abort  in  1  cancel the current operation
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- req_valid  out  1  address request valid
- req_ready  in  1  memory accepts request
- req_addr  out  ADDR_W  element address
- req_idx  out  IDX_W  element index
- req_last  out  1  current request is element vl-1

## Operation
- FSM states: IDLE, RUN. Reset: IDLE, vl register 0, all outputs 0.
- IDLE & start: snapshot vl, base, stride, mode, ew; if snapshot vl = 0, pulse done next cycle and stay IDLE; else go to RUN with idx 0, req_addr = base.
- RUN: req_valid = 1. On req_valid & req_ready: if req_last, pulse done and go to IDLE; else idx+1 and update address.
- UNIT address: base + (idx << ew). STRIDED: previous address + stride. All sums modulo 2**ADDR_W (wrap silently, no flag).
- req_last = (idx == snapshot vl - 1).
- Outputs hold stable while req_valid & !req_ready.
- vl_we accepted in any state; updates the register only, never the running operation's snapshot. vl_we with start in the same IDLE cycle: start uses the old vl.
- start while RUN: ignored, no side effects.
- abort in RUN: next cycle IDLE, req_valid = 0, no done pulse; a handshake in the abort cycle completes but is the final one. abort in IDLE: no effect. abort has priority over start.
- busy = (state == RUN).

## Timing
- start sampled at edge T -> busy, req_valid, idx 0 visible after edge T.
- One element per cycle at full throughput (req_ready held high): vl requests in vl consecutive cycles.
- Last handshake at edge L -> done = 1 and busy = 0 for the cycle after L; a new start is accepted in that same cycle.
- vl = 0: done pulses the cycle after start; req_valid never asserted.
- rst_n low mid-operation: all outputs return to 0 immediately; vl register cleared.

## Structure
- Package vlsu_pkg: state enum (IDLE, RUN), mode constants (MODE_UNIT, MODE_STRIDED), ew encodings and the ew-to-byte-shift mapping.
- One sub-module is natural: vlsu_addr_step, combinational next-address logic (unit shift vs. stride accumulate, modulo ADDR_W).

## Test plan
- vl=4, UNIT, ew=2, base=0x1000, req_ready=1 -> addrs 0x1000, 0x1004, 0x1008, 0x100C, idx 0..3, req_last on idx 3, done the next cycle.
- vl=3, STRIDED, stride=-8, base=0x0000_0010 -> addrs 0x10, 0x08, 0x00; ready held low 2 cycles on idx 1 -> addr/idx held stable.
- vl=2, STRIDED, base=0xFFFF_FFFC, stride=8 -> 0xFFFF_FFFC, 0x0000_0004 (wrap).
- vl_we=1, vl_in=0, then start -> done pulse 1 cycle after start, req_valid stays 0; vl_in=31 with IDX_W=4 saturates to 16 elements.
- vl=8 running, abort at idx 2 -> IDLE next cycle, no done; start in same cycle as abort ignored; vl_we mid-run does not change element count.
- rst_n asserted at idx 5 -> busy, req_valid, done, req_addr immediately 0; following start with vl register 0 -> done-only response.
